// File: rtl/dcache_flush_engine_if.sv
// Dcache flush engine bus bundle: SRAM tag/data port and data-memory port.
// The master side is the flush engine; the slave side is the SRAM/memory.
interface dcache_flush_engine_if #(
    parameter int IDX_W  = 4,
    parameter int WAY_W  = 1,
    parameter int TAG_W  = 25,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic [IDX_W-1:0]  sram_idx_o;
    logic [WAY_W-1:0]  sram_way_o;
    logic [TAG_W-1:0]  sram_tag_i;
    logic [LINE_W-1:0] sram_data_i;
    logic              sram_we_o;
    logic [TAG_W-1:0]  sram_tag_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;

    modport master (
        output sram_idx_o, sram_way_o, sram_we_o, sram_tag_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  sram_tag_i, sram_data_i, mem_ack_i
    );

    modport slave (
        input  sram_idx_o, sram_way_o, sram_we_o, sram_tag_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output sram_tag_i, sram_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_flush_engine.sv
// Dcache maintenance engine: walks every set/way, writes back dirty lines,
// then clears dirty (clean) or dirty+valid (invalidate) in the tag SRAM.
module dcache_flush_engine #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int TAG_W    = 25,
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int OFF_W   = $clog2(LINE_W / 8),
    localparam int CNT_W   = IDX_W + WAY_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] wb_count_o,
    dcache_flush_engine_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  set_q;
    logic [WAY_W-1:0]  way_q;
    logic              mode_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              advance;
    logic              cnt_inc;
    logic              last;
    logic              in_v;
    logic              in_d;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic              tag_we;

    assign in_v = bus.sram_tag_i[TAG_W-1];
    assign in_d = bus.sram_tag_i[TAG_W-2];
    assign last = (set_q == LAST_SET) && (way_q == LAST_WAY);

    // Next-state and strobe decode; reset masks strobes in the same cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        cnt_inc = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        mem_en  = 1'b0;
        tag_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (in_v && in_d) begin
                    state_d = S_WRITE;
                end else if (mode_q && in_v) begin
                    state_d = S_UPDATE;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WRITE: begin
                mem_en = 1'b1;
                if (bus.mem_ack_i) begin
                    cnt_inc = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                tag_we  = 1'b1;
                advance = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (advance) begin
            state_d = last ? S_DONE : S_READ;
        end
        if (rst_i) begin
            busy   = 1'b0;
            done   = 1'b0;
            mem_en = 1'b0;
            tag_we = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Walk counters, captured entry and write-back count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            set_q  <= '0;
            way_q  <= '0;
            mode_q <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                set_q  <= '0;
                way_q  <= '0;
                cnt_q  <= '0;
                mode_q <= mode_i;
            end
            if (state_q == S_CHECK) begin
                tag_q  <= bus.sram_tag_i;
                data_q <= bus.sram_data_i;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (advance) begin
                if (way_q == LAST_WAY) begin
                    way_q <= '0;
                    set_q <= set_q + IDX_W'(1);
                end else begin
                    way_q <= way_q + WAY_W'(1);
                end
            end
        end
    end

    assign busy_o           = busy;
    assign done_o           = done;
    assign wb_count_o       = cnt_q;

    assign bus.sram_idx_o   = set_q;
    assign bus.sram_way_o   = way_q;
    assign bus.sram_we_o    = tag_we;
    assign bus.sram_tag_o   = {tag_q[TAG_W-1] & ~mode_q, 1'b0,
                               tag_q[TAG_W-3:0]};

    assign bus.mem_enable_o = mem_en;
    assign bus.mem_write_o  = mem_en;
    assign bus.mem_addr_o   = {tag_q[TAG_W-3:0], set_q, {OFF_W{1'b0}}};
    assign bus.mem_data_o   = data_q;

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Bench for dcache_flush_engine: default instance plus a 4x4 sweep instance,
// SRAM/memory models and a queue scoreboard of write-backs and tag updates.
module tb_dcache_flush_engine;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } mw_t;
    typedef struct {
        logic [3:0]  idx;
        logic        way;
        logic [24:0] tag;
    } twa_t;
    typedef struct {
        logic [1:0]  idx;
        logic [1:0]  way;
        logic [26:0] tag;
    } twb_t;

    int checks = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_start = 1'b0, a_mode = 1'b0, a_busy, a_done;
    logic [5:0] a_wb;
    logic       b_start = 1'b0, b_mode = 1'b0, b_busy, b_done;
    logic [4:0] b_wb;

    dcache_flush_engine_if #(.IDX_W(4), .WAY_W(1), .TAG_W(25),
        .LINE_W(256), .ADDR_W(32)) a_if ();
    dcache_flush_engine_if #(.IDX_W(2), .WAY_W(2), .TAG_W(27),
        .LINE_W(256), .ADDR_W(32)) b_if ();

    dcache_flush_engine #(.NUM_SETS(16), .NUM_WAYS(2), .TAG_W(25),
        .LINE_W(256), .ADDR_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .mode_i(a_mode),
        .busy_o(a_busy), .done_o(a_done), .wb_count_o(a_wb),
        .bus(a_if.master));

    dcache_flush_engine #(.NUM_SETS(4), .NUM_WAYS(4), .TAG_W(27),
        .LINE_W(256), .ADDR_W(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .mode_i(b_mode),
        .busy_o(b_busy), .done_o(b_done), .wb_count_o(b_wb),
        .bus(b_if.master));

    // SRAM models: one-cycle read latency, bench load port or DUT writes
    logic [24:0]  a_tagm  [16][2];
    logic [255:0] a_datam [16][2];
    logic         a_ld = 1'b0;
    logic [3:0]   a_ld_i = '0;
    logic         a_ld_w = 1'b0;
    logic [24:0]  a_ld_tag = '0;
    logic [255:0] a_ld_data = '0;

    always @(posedge clk) begin
        if (a_ld) begin
            a_tagm[a_ld_i][a_ld_w]  <= a_ld_tag;
            a_datam[a_ld_i][a_ld_w] <= a_ld_data;
        end else if (a_if.sram_we_o) begin
            a_tagm[a_if.sram_idx_o][a_if.sram_way_o] <= a_if.sram_tag_o;
        end
        a_if.sram_tag_i  <= a_tagm[a_if.sram_idx_o][a_if.sram_way_o];
        a_if.sram_data_i <= a_datam[a_if.sram_idx_o][a_if.sram_way_o];
    end

    logic [26:0]  b_tagm  [4][4];
    logic [255:0] b_datam [4][4];
    logic         b_ld = 1'b0;
    logic [1:0]   b_ld_i = '0;
    logic [1:0]   b_ld_w = '0;
    logic [26:0]  b_ld_tag = '0;
    logic [255:0] b_ld_data = '0;

    always @(posedge clk) begin
        if (b_ld) begin
            b_tagm[b_ld_i][b_ld_w]  <= b_ld_tag;
            b_datam[b_ld_i][b_ld_w] <= b_ld_data;
        end else if (b_if.sram_we_o) begin
            b_tagm[b_if.sram_idx_o][b_if.sram_way_o] <= b_if.sram_tag_o;
        end
        b_if.sram_tag_i  <= b_tagm[b_if.sram_idx_o][b_if.sram_way_o];
        b_if.sram_data_i <= b_datam[b_if.sram_idx_o][b_if.sram_way_o];
    end

    // Memory models: ack after a_lat low cycles, plus a stray ack input
    int   a_lat = 0;
    int   a_wait = 0;
    logic a_stray = 1'b0;
    assign a_if.mem_ack_i = (a_if.mem_enable_o && (a_wait == a_lat))
                            || a_stray;
    always @(posedge clk) begin
        if (a_if.mem_enable_o && !a_if.mem_ack_i) a_wait <= a_wait + 1;
        else a_wait <= 0;
    end
    assign b_if.mem_ack_i = b_if.mem_enable_o;

    // Monitors: record completed writes, tag updates, done pulses
    mw_t  a_obs_mem[$], a_exp_mem[$], b_obs_mem[$], b_exp_mem[$];
    twa_t a_obs_tw[$], a_exp_tw[$];
    twb_t b_obs_tw[$], b_exp_tw[$];
    int   a_done_n = 0;
    int   a_unstable = 0;
    int   wr_bad = 0;
    logic a_prev_en = 1'b0;
    logic [31:0]  a_prev_addr = '0;
    logic [255:0] a_prev_data = '0;

    always @(negedge clk) begin
        if (a_if.mem_enable_o && a_if.mem_ack_i)
            a_obs_mem.push_back('{addr: a_if.mem_addr_o,
                                  data: a_if.mem_data_o});
        if (a_if.sram_we_o)
            a_obs_tw.push_back('{idx: a_if.sram_idx_o,
                                 way: a_if.sram_way_o,
                                 tag: a_if.sram_tag_o});
        if (b_if.mem_enable_o && b_if.mem_ack_i)
            b_obs_mem.push_back('{addr: b_if.mem_addr_o,
                                  data: b_if.mem_data_o});
        if (b_if.sram_we_o)
            b_obs_tw.push_back('{idx: b_if.sram_idx_o,
                                 way: b_if.sram_way_o,
                                 tag: b_if.sram_tag_o});
        if (a_done) a_done_n <= a_done_n + 1;
        if (a_if.mem_enable_o && a_prev_en &&
            (a_if.mem_addr_o !== a_prev_addr ||
             a_if.mem_data_o !== a_prev_data))
            a_unstable <= a_unstable + 1;
        if (a_if.mem_write_o !== a_if.mem_enable_o ||
            b_if.mem_write_o !== b_if.mem_enable_o)
            wr_bad <= wr_bad + 1;
        a_prev_en   <= a_if.mem_enable_o;
        a_prev_addr <= a_if.mem_addr_o;
        a_prev_data <= a_if.mem_data_o;
    end

    // Shadow of instance A SRAM used by the reference model
    logic [24:0]  sh_tag  [16][2];
    logic [255:0] sh_data [16][2];

    function automatic logic [255:0] pat(int s, int w);
        return {8{32'hC0DE0000 | 32'(s * 8 + w)}};
    endfunction

    task automatic load_a(input int s, input int w,
                          input logic [24:0] t, input logic [255:0] d);
        sh_tag[s][w]  = t;
        sh_data[s][w] = d;
        @(negedge clk);
        a_ld = 1'b1; a_ld_i = 4'(s); a_ld_w = 1'(w);
        a_ld_tag = t; a_ld_data = d;
        @(negedge clk);
        a_ld = 1'b0;
    endtask

    task automatic clear_a();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++)
                load_a(s, w, '0, '0);
    endtask

    // Reference walk: expected cycles, write-backs and tag updates
    task automatic model_a(input logic m, input int lat, output int cyc);
        logic [24:0] t, nt;
        cyc = 0;
        a_exp_mem.delete();
        a_exp_tw.delete();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                t = sh_tag[s][w];
                if (t[24] && t[23]) begin
                    cyc += 4 + lat;
                    a_exp_mem.push_back('{addr: {t[22:0], 4'(s), 5'b0},
                                          data: sh_data[s][w]});
                    nt = {~m, 1'b0, t[22:0]};
                    a_exp_tw.push_back('{idx: 4'(s), way: 1'(w), tag: nt});
                    sh_tag[s][w] = nt;
                end else if (m && t[24]) begin
                    cyc += 3;
                    nt = {1'b0, 1'b0, t[22:0]};
                    a_exp_tw.push_back('{idx: 4'(s), way: 1'(w), tag: nt});
                    sh_tag[s][w] = nt;
                end else begin
                    cyc += 2;
                end
            end
        end
    endtask

    // Start A and count edges until done; optional start poke mid-walk
    task automatic run_a(input logic m, input int lat, input int poke,
                         output int n);
        a_lat = lat;
        a_obs_mem.delete();
        a_obs_tw.delete();
        @(negedge clk);
        a_mode = m; a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        n = 0;
        while (n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            if (poke > 0 && n == poke) begin
                a_start = 1'b1; a_mode = ~m;
            end else if (poke > 0 && n == poke + 1) begin
                a_start = 1'b0; a_mode = m;
            end
            if (a_done) break;
        end
        a_start = 1'b0; a_mode = m;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            failures++; $display("FAIL rst_busy: got %b want 0", a_busy);
        end
        checks++;
        if (a_done !== 1'b0) begin
            failures++; $display("FAIL rst_done: got %b want 0", a_done);
        end
        checks++;
        if (a_wb !== 6'd0) begin
            failures++; $display("FAIL rst_wb: got %0d want 0", a_wb);
        end
        checks++;
        if (a_if.mem_enable_o !== 1'b0 || a_if.sram_we_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_strobes: got en=%b we=%b want 0 0",
                     a_if.mem_enable_o, a_if.sram_we_o);
        end
        checks++;
        if (a_if.mem_addr_o !== 32'd0 || a_if.sram_idx_o !== 4'd0) begin
            failures++;
            $display("FAIL rst_addr: got addr=%h idx=%0d want 0 0",
                     a_if.mem_addr_o, a_if.sram_idx_o);
        end
        checks++;
        if (b_busy !== 1'b0 || b_wb !== 5'd0) begin
            failures++;
            $display("FAIL rst_b: got busy=%b wb=%0d want 0 0", b_busy, b_wb);
        end
    endtask

    task automatic test_all_invalid();
        int n, exp;
        clear_a();
        model_a(1'b0, 0, exp);
        run_a(1'b0, 0, 0, n);
        checks++;
        if (n !== 64) begin
            failures++; $display("FAIL inv_cycles: got %0d want 64", n);
        end
        checks++;
        if (a_wb !== 6'd0) begin
            failures++; $display("FAIL inv_wb: got %0d want 0", a_wb);
        end
        checks++;
        if (a_obs_mem.size() != 0 || a_obs_tw.size() != 0) begin
            failures++;
            $display("FAIL inv_access: got mem=%0d tag=%0d want 0 0",
                     a_obs_mem.size(), a_obs_tw.size());
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL inv_idle: got busy=%b done=%b want 0 0",
                     a_busy, a_done);
        end
    endtask

    task automatic test_dirty_line();
        int n, exp, u0;
        mw_t e, o;
        twa_t et, ot;
        clear_a();
        load_a(3, 1, 25'h1800005, pat(3, 1));
        model_a(1'b0, 9, exp);
        u0 = a_unstable;
        run_a(1'b0, 9, 0, n);
        checks++;
        if (n !== 75) begin
            failures++; $display("FAIL dirty_cycles: got %0d want 75", n);
        end
        checks++;
        if (a_wb !== 6'd1) begin
            failures++; $display("FAIL dirty_wb: got %0d want 1", a_wb);
        end
        checks++;
        if (a_obs_mem.size() != 1 || a_obs_tw.size() != 1) begin
            failures++;
            $display("FAIL dirty_counts: got mem=%0d tag=%0d want 1 1",
                     a_obs_mem.size(), a_obs_tw.size());
        end else begin
            o = a_obs_mem.pop_front(); e = a_exp_mem.pop_front();
            checks++;
            if (o.addr !== 32'h00000A60 || o.data !== e.data) begin
                failures++;
                $display("FAIL dirty_mem: got %h/%h want 00000a60/%h",
                         o.addr, o.data, e.data);
            end
            ot = a_obs_tw.pop_front(); et = a_exp_tw.pop_front();
            checks++;
            if (ot.tag !== 25'h1000005 || ot.idx !== 4'd3 ||
                ot.way !== 1'b1 || ot.tag !== et.tag) begin
                failures++;
                $display("FAIL dirty_tag: got %h@%0d/%0d want 1000005@3/1",
                         ot.tag, ot.idx, ot.way);
            end
        end
        checks++;
        if (a_unstable != u0) begin
            failures++;
            $display("FAIL dirty_stable: got %0d changes want 0",
                     a_unstable - u0);
        end
    endtask

    task automatic test_mode1_mixed();
        int n, exp, nv;
        mw_t e, o;
        twa_t et, ot;
        clear_a();
        for (int s = 0; s < 16; s++)
            load_a(s, 0, {2'b10, 23'(16'h100 + s)}, pat(s, 0));
        load_a(2, 1, {2'b11, 23'h2A}, pat(2, 1));
        model_a(1'b1, 2, exp);
        run_a(1'b1, 2, 0, n);
        checks++;
        if (n !== 84 || n !== exp) begin
            failures++;
            $display("FAIL m1_cycles: got %0d want 84 (model %0d)", n, exp);
        end
        checks++;
        if (a_obs_tw.size() != 17 || a_obs_mem.size() != 1) begin
            failures++;
            $display("FAIL m1_counts: got tag=%0d mem=%0d want 17 1",
                     a_obs_tw.size(), a_obs_mem.size());
        end
        while (a_exp_tw.size() > 0 && a_obs_tw.size() > 0) begin
            et = a_exp_tw.pop_front(); ot = a_obs_tw.pop_front();
            checks++;
            if (ot.idx !== et.idx || ot.way !== et.way ||
                ot.tag !== et.tag) begin
                failures++;
                $display("FAIL m1_tag: got %h@%0d/%0d want %h@%0d/%0d",
                         ot.tag, ot.idx, ot.way, et.tag, et.idx, et.way);
            end
        end
        while (a_exp_mem.size() > 0 && a_obs_mem.size() > 0) begin
            e = a_exp_mem.pop_front(); o = a_obs_mem.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                failures++;
                $display("FAIL m1_mem: got %h want %h", o.addr, e.addr);
            end
        end
        nv = 0;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++)
                if (a_tagm[s][w][24] !== 1'b0) nv++;
        checks++;
        if (nv != 0) begin
            failures++; $display("FAIL m1_valid_left: got %0d want 0", nv);
        end
        checks++;
        if (a_wb !== 6'd1) begin
            failures++; $display("FAIL m1_wb: got %0d want 1", a_wb);
        end
    endtask

    task automatic test_reset_during_write();
        int k, n, exp;
        mw_t o;
        clear_a();
        load_a(0, 0, 25'h1800077, pat(0, 0));
        a_obs_mem.delete();
        a_obs_tw.delete();
        a_lat = 20;
        @(negedge clk);
        a_mode = 1'b0; a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        k = 0;
        while (!a_if.mem_enable_o && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (a_if.mem_enable_o !== 1'b1) begin
            failures++; $display("FAIL rw_reach: got en=0 want 1");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_if.mem_enable_o !== 1'b0 || a_if.sram_we_o !== 1'b0) begin
            failures++;
            $display("FAIL rw_drop: got en=%b we=%b want 0 0",
                     a_if.mem_enable_o, a_if.sram_we_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_if.mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL rw_idle: got busy=%b en=%b want 0 0",
                     a_busy, a_if.mem_enable_o);
        end
        a_stray = 1'b1;
        @(posedge clk);
        #1 a_stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_wb !== 6'd0) begin
            failures++;
            $display("FAIL rw_late_ack: got busy=%b wb=%0d want 0 0",
                     a_busy, a_wb);
        end
        checks++;
        if (a_obs_tw.size() != 0 || a_tagm[0][0] !== 25'h1800077) begin
            failures++;
            $display("FAIL rw_no_update: got n=%0d tag=%h want 0 1800077",
                     a_obs_tw.size(), a_tagm[0][0]);
        end
        load_a(0, 0, '0, '0);
        load_a(3, 1, 25'h1800005, pat(3, 1));
        model_a(1'b0, 9, exp);
        run_a(1'b0, 9, 0, n);
        checks++;
        if (n !== 75 || a_wb !== 6'd1) begin
            failures++;
            $display("FAIL rw_rerun: got cyc=%0d wb=%0d want 75 1", n, a_wb);
        end
        checks++;
        if (a_obs_mem.size() != 1) begin
            failures++;
            $display("FAIL rw_rerun_mem: got %0d want 1", a_obs_mem.size());
        end else begin
            o = a_obs_mem.pop_front();
            checks++;
            if (o.addr !== 32'h00000A60) begin
                failures++;
                $display("FAIL rw_rerun_addr: got %h want 00000a60", o.addr);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int n, exp, d0;
        twa_t et, ot;
        clear_a();
        load_a(1, 0, {2'b10, 23'h11}, pat(1, 0));
        load_a(5, 1, {2'b11, 23'h55}, pat(5, 1));
        load_a(9, 0, {2'b10, 23'h99}, pat(9, 0));
        model_a(1'b0, 3, exp);
        d0 = a_done_n;
        run_a(1'b0, 3, 10, n);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (n !== 69 || n !== exp) begin
            failures++;
            $display("FAIL swb_cycles: got %0d want 69 (model %0d)", n, exp);
        end
        checks++;
        if (a_done_n - d0 != 1) begin
            failures++;
            $display("FAIL swb_done: got %0d pulses want 1", a_done_n - d0);
        end
        checks++;
        if (a_obs_tw.size() != 1 || a_wb !== 6'd1) begin
            failures++;
            $display("FAIL swb_counts: got tag=%0d wb=%0d want 1 1",
                     a_obs_tw.size(), a_wb);
        end else begin
            ot = a_obs_tw.pop_front(); et = a_exp_tw.pop_front();
            checks++;
            if (ot.tag !== et.tag || ot.idx !== et.idx || ot.way !== et.way)
            begin
                failures++;
                $display("FAIL swb_tag: got %h@%0d want %h@%0d",
                         ot.tag, ot.idx, et.tag, et.idx);
            end
        end
        checks++;
        if (a_tagm[1][0] !== 25'h1000011 || a_tagm[9][0] !== 25'h1000099)
        begin
            failures++;
            $display("FAIL swb_clean_kept: got %h %h want 1000011 1000099",
                     a_tagm[1][0], a_tagm[9][0]);
        end
    endtask

    task automatic test_sweep();
        int n;
        logic [24:0] t;
        mw_t e, o;
        twb_t et, ot;
        b_exp_mem.delete();
        b_exp_tw.delete();
        b_obs_mem.delete();
        b_obs_tw.delete();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 4; w++) begin
                t = 25'(32'h1000 + s * 4 + w);
                @(negedge clk);
                b_ld = 1'b1; b_ld_i = 2'(s); b_ld_w = 2'(w);
                b_ld_tag = {2'b11, t}; b_ld_data = pat(s, w);
                b_exp_mem.push_back('{addr: {t, 2'(s), 5'b0},
                                      data: pat(s, w)});
                b_exp_tw.push_back('{idx: 2'(s), way: 2'(w),
                                     tag: {2'b10, t}});
            end
        end
        @(negedge clk);
        b_ld = 1'b0;
        b_mode = 1'b0; b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        n = 0;
        while (n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            if (b_done) break;
        end
        checks++;
        if (n !== 64) begin
            failures++; $display("FAIL sweep_cycles: got %0d want 64", n);
        end
        checks++;
        if (b_wb !== 5'd16 || b_obs_mem.size() != 16 ||
            b_obs_tw.size() != 16) begin
            failures++;
            $display("FAIL sweep_counts: got wb=%0d mem=%0d tag=%0d want 16",
                     b_wb, b_obs_mem.size(), b_obs_tw.size());
        end
        while (b_exp_mem.size() > 0 && b_obs_mem.size() > 0) begin
            e = b_exp_mem.pop_front(); o = b_obs_mem.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                failures++;
                $display("FAIL sweep_mem: got %h want %h", o.addr, e.addr);
            end
        end
        while (b_exp_tw.size() > 0 && b_obs_tw.size() > 0) begin
            et = b_exp_tw.pop_front(); ot = b_obs_tw.pop_front();
            checks++;
            if (ot.tag !== et.tag || ot.idx !== et.idx || ot.way !== et.way)
            begin
                failures++;
                $display("FAIL sweep_tag: got %h@%0d/%0d want %h@%0d/%0d",
                         ot.tag, ot.idx, ot.way, et.tag, et.idx, et.way);
            end
        end
        checks++;
        if (wr_bad != 0) begin
            failures++;
            $display("FAIL write_eq_enable: got %0d cycles want 0", wr_bad);
        end
    endtask

    initial begin
        test_reset();
        test_all_invalid();
        test_dirty_line();
        test_mode1_mixed();
        test_reset_during_write();
        test_start_while_busy();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_flush_engine.md
# dcache_flush_engine

Parametrised hardware cache-maintenance engine for the CPU data cache. On a start pulse it walks every set and way of the dcache SRAM and writes each valid+dirty line back to data memory over the existing enable/write/ack memory port. In clean mode it then clears the dirty bit; in invalidate mode it also clears the valid bit. It sits beside the dcache controller, arbitrated onto the same SRAM port and memory port while `busy_o` is high; the dcache stalls the CPU for that duration.

## Interface
- `NUM_SETS`, 16, number of sets; power of two, ≥2; `IDX_W = log2(NUM_SETS)`.
- `NUM_WAYS`, 2, ways per set; power of two, ≥1; `WAY_W = max(1, log2(NUM_WAYS))`.
- `TAG_W`, 25, SRAM tag-entry width, laid out as {valid[TAG_W-1], dirty[TAG_W-2], addr_tag[TAG_W-3:0]}.
- `LINE_W`, 256, line width in bits; `OFF_W = log2(LINE_W/8)`.
- `ADDR_W`, 32, memory address width. Legal only if (TAG_W-2)+IDX_W+OFF_W == ADDR_W.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  one-cycle request; sampled only in IDLE.
- `mode_i`  in  1  0 = clean, 1 = clean+invalidate; latched when start is accepted.
- `busy_o`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `done_o`  out  1  one-cycle completion pulse.
- `wb_count_o`  out  IDX_W+WAY_W+1  lines written back in the last or current operation.
- `sram_idx_o`  out  IDX_W  set index under access.
- `sram_way_o`  out  WAY_W  way under access.
- `sram_tag_i`  in  TAG_W  tag entry; valid one cycle after idx/way are presented.
- `sram_data_i`  in  LINE_W  line data, same timing as `sram_tag_i`.
- `sram_we_o`  out  1  tag write strobe; data is never written.
- `sram_tag_o`  out  TAG_W  tag value written on `sram_we_o`.
- `mem_enable_o`  out  1  memory request; held until ack.
- `mem_write_o`  out  1  equals `mem_enable_o`, because the engine only writes.
- `mem_addr_o`  out  ADDR_W  {addr_tag, index, OFF_W'b0}.
- `mem_data_o`  out  LINE_W  captured line data.
- `mem_ack_i`  in  1  one-cycle completion from data memory.

## Operation
- States: IDLE, READ, CHECK, WRITE, UPDATE, DONE.
- **IDLE**
  - When `start_i` is high: clear the set/way counters and `wb_count_o`, latch `mode_i`, go to READ.
  - `start_i` in any other state is ignored.
- **READ**
  - Drive `sram_idx_o` and `sram_way_o` from the counters.
  - Go to CHECK.
- **CHECK**
  - Register `sram_tag_i` and `sram_data_i`.
  - If valid && dirty, go to WRITE.
  - Else, if mode=1 && valid, go to UPDATE.
  - Otherwise advance the counters.
- **WRITE**
  - Drive `mem_enable_o` = `mem_write_o` = 1, with the address and data from the registered copies.
  - On `mem_ack_i`: increment `wb_count_o`, drop the request, go to UPDATE.
- **UPDATE**
  - Pulse `sram_we_o` with `sram_tag_o` = registered tag, with dirty=0 and, in mode 1, valid=0.
  - Then advance the counters.
- **Advance**
  - The way index increments first; on wrap it returns to 0 and the set index increments.
  - After the last entry (set NUM_SETS-1, way NUM_WAYS-1), go to DONE; otherwise go to READ.
- **DONE**
  - `done_o` = 1 for one cycle, then IDLE.
- Entry handling by state of the line:
  - Invalid entries are never written or modified.
  - In mode 0, clean valid entries are untouched.
  - In mode 1, clean valid entries are invalidated without a memory access.
- `wb_count_o` holds its value after DONE until the next accepted start.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Reset mid-operation:**
  - Return to IDLE on the next edge.
  - Drop `mem_enable_o` immediately in that cycle; the abandoned memory ack is ignored.
  - Issue no `sram_we_o`.
- **Per-entry cost:**
  - Skipped entry: 2 cycles (READ, CHECK).
  - Invalidate-only entry: 3 cycles.
  - Write-back entry: 4 + L cycles, where L = number of cycles `mem_ack_i` stays low in WRITE (L=0 if ack arrives in the first WRITE cycle).
- **Completion:** with start accepted at edge E0, `done_o` is high in the cycle following edge E0 + (sum of entry costs).
- **Ack handling:**
  - `mem_ack_i` is only sampled in WRITE.
  - An ack in any other state is ignored.
- **Request stability:** `mem_addr_o` and `mem_data_o` are stable throughout WRITE.

## Test plan
- **All invalid, mode 0, defaults:** start → `done_o` exactly 64 cycles after start, `wb_count_o`=0, no `mem_enable_o` or `sram_we_o`.
- **Dirty line at set 3 way 1:** tag=25'h1800005, mode 0, memory ack latency 9 → one write to `mem_addr_o`=32'h00000A60 with the line data; `sram_tag_o`=25'h1000005; `wb_count_o`=1.
- **Mode 1, mixed contents:** sets 0–15 way 0 valid-clean, set 2 way 1 dirty → all 16 valid-clean entries rewritten with valid=0 and 1 write-back; afterwards every SRAM tag has valid=0.
- **Reset during WRITE:** assert `rst_i` during WRITE before ack → next cycle `busy_o`=0 and `mem_enable_o`=0, no tag update; a late ack is ignored, and a new start behaves like the first scenario.
- **Start while busy:** pulse `start_i` at mid-walk → ignored; exactly one `done_o` pulse and `mode_i` changes not picked up.
- **Parameter sweep:** NUM_SETS=4, NUM_WAYS=4, TAG_W=27, with all entries dirty and ack latency 0 → 16 write-backs, `done_o` at 16×4=64 cycles after start, addresses cover all {tag, idx}.
